// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_arbiter
// Purpose  : Shares one single-port memory between the rv32i fetch (I) and
//            load/store (D) ports. D has priority, I has a starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam int BW = DW / 8;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  localparam logic [0:0]    c_st_idle    = 1'b0;
  localparam logic [0:0]    c_st_busy    = 1'b1;
  localparam logic          c_own_i      = 1'b0;
  localparam logic          c_own_d      = 1'b1;
  localparam logic [CW-1:0] c_cnt_init   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] c_streak_max = SW'(STARVE_LIM);

  logic [0:0]    r_state;
  logic          r_owner;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_streak;

  logic w_idle;
  logic w_gnt_d;
  logic w_gnt_i;
  logic w_done;

  // Outputs are gated with rst so everything reads zero while reset is held.
  assign w_idle  = !rst && (r_state == c_st_idle);
  assign w_gnt_d = w_idle && d_req && !(i_req && (r_streak == c_streak_max));
  assign w_gnt_i = w_idle && i_req && !w_gnt_d;
  assign w_done  = !rst && (r_state == c_st_busy) && (r_cnt == '0);

  assign i_gnt    = w_gnt_i;
  assign d_gnt    = w_gnt_d;
  assign m_en     = w_gnt_i || w_gnt_d;
  assign m_we     = w_gnt_d ? d_we : 1'b0;
  assign m_be     = w_gnt_d ? d_be : (w_gnt_i ? {BW{1'b1}} : '0);
  assign m_addr   = w_gnt_d ? d_addr : (w_gnt_i ? i_addr : '0);
  assign m_wdata  = w_gnt_d ? d_wdata : '0;

  assign i_rvalid = w_done && (r_owner == c_own_i);
  assign d_rvalid = w_done && (r_owner == c_own_d);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_owner  <= c_own_i;
      r_cnt    <= '0;
      r_streak <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_gnt_d || w_gnt_i) begin
            r_state <= c_st_busy;
            r_owner <= w_gnt_d ? c_own_d : c_own_i;
            r_cnt   <= c_cnt_init;
          end
          // Streak only grows while I is actually being passed over.
          if (w_gnt_i) begin
            r_streak <= '0;
          end else if (w_gnt_d) begin
            if (!i_req) begin
              r_streak <= '0;
            end else if (r_streak != c_streak_max) begin
              r_streak <= r_streak + SW'(1);
            end
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_state <= c_st_idle;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mem_arbiter
// Purpose  : Scoreboard bench for rv32i_mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

  typedef struct {
    bit          port;   // 0=I, 1=D
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] m_rdata;

  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_en, a_m_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic [3:0]  a_m_be;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic [3:0]  b_m_be;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat;
  gnt_t exp_q[$];
  rsp_t rsp_q[$];
  int   gnt_cyc[$];
  logic [31:0] pipe [3];

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .m_en(a_m_en), .m_we(a_m_we), .m_be(a_m_be), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_rdata(m_rdata)
  );

  rv32i_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_be(b_m_be), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(m_rdata)
  );

  always_comb begin
    i_gnt    = sel ? b_i_gnt    : a_i_gnt;
    i_rvalid = sel ? b_i_rvalid : a_i_rvalid;
    i_rdata  = sel ? b_i_rdata  : a_i_rdata;
    d_gnt    = sel ? b_d_gnt    : a_d_gnt;
    d_rvalid = sel ? b_d_rvalid : a_d_rvalid;
    d_rdata  = sel ? b_d_rdata  : a_d_rdata;
    m_en     = sel ? b_m_en     : a_m_en;
    m_we     = sel ? b_m_we     : a_m_we;
    m_be     = sel ? b_m_be     : a_m_be;
    m_addr   = sel ? b_m_addr   : a_m_addr;
    m_wdata  = sel ? b_m_wdata  : a_m_wdata;
    m_rdata  = sel ? pipe[2]    : pipe[0];
    lat      = sel ? 3 : 1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Fixed-latency memory model driven by whichever arbiter is selected.
  always @(posedge clk) begin
    pipe[0] <= m_en ? mem_word(m_addr) : 32'h0BAD_0BAD;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
    cyc     <= cyc + 1;
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    gnt_t e;
    rsp_t r;
    if (rst) begin
      chk_val("rst_zero", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, |m_be, |m_addr,
                           |m_wdata, |i_rdata, |d_rdata}, 0);
      rsp_q.delete();
    end else begin
      chk_val("gnt_excl", i_gnt & d_gnt, 0);
      if (i_gnt || d_gnt) begin
        chk_val("m_en", m_en, 1);
        if (exp_q.size() == 0) begin
          chk_val("gnt_unexp", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk_val("gnt_port", d_gnt, e.port);
          chk_val("m_addr", m_addr, e.addr);
          chk_val("m_we", m_we, e.we);
          chk_val("m_be", m_be, e.be);
          chk_val("m_wdata", m_wdata, e.wdata);
          chk_val("gnt_busy", rsp_q.size(), 0);
          r.port = e.port;
          r.data = mem_word(e.addr);
          r.due  = cyc + lat;
          rsp_q.push_back(r);
          gnt_cyc.push_back(cyc);
        end
      end else begin
        chk_val("m_en_idle", m_en, 0);
      end
      if (i_rvalid || d_rvalid) begin
        chk_val("rv_excl", i_rvalid & d_rvalid, 0);
        if (rsp_q.size() == 0) begin
          chk_val("rv_unexp", rsp_q.size(), 1);
        end else begin
          r = rsp_q.pop_front();
          chk_val("rv_port", d_rvalid, r.port);
          chk_val("rv_cyc", cyc, r.due);
          chk_val("rdata", r.port ? d_rdata : i_rdata, r.data);
        end
      end else if (rsp_q.size() != 0 && cyc >= rsp_q[0].due) begin
        r = rsp_q.pop_front();
        chk_val("rv_late", {i_rvalid, d_rvalid}, r.port ? 2'b01 : 2'b10);
      end
      if (!i_rvalid) chk_val("i_rdata0", i_rdata, 0);
      if (!d_rvalid) chk_val("d_rdata0", d_rdata, 0);
    end
  end

  task automatic push_i(input logic [31:0] a);
    gnt_t e;
    e.port = 1'b0; e.addr = a; e.we = 1'b0; e.be = 4'hF; e.wdata = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input bit we, input logic [3:0] be,
                        input logic [31:0] wd);
    gnt_t e;
    e.port = 1'b1; e.addr = a; e.we = we; e.be = be; e.wdata = wd;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk); #1;
    rst = 1'b1;
    sel = s;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    gnt_cyc.delete();
  endtask

  // Wait for n grants; each requester drops its request after its grant unless hold.
  task automatic run(input int n, input bit hold);
    int got = 0;
    bit gi, gd;
    for (int k = 0; k < 200 && got < n; k++) begin
      @(negedge clk);
      gi = i_gnt;
      gd = d_gnt;
      got += int'(gi) + int'(gd);
      @(posedge clk); #1;
      if (!hold && gi) i_req = 1'b0;
      if (!hold && gd) d_req = 1'b0;
    end
    if (hold) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    chk_val("run_grants", got, n);
  endtask

  task automatic drain;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk_val("drain_gnt", exp_q.size(), 0);
    chk_val("drain_rsp", rsp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Single fetch, MEM_LAT=1
    push_i(32'h10);
    i_addr = 32'h10; i_req = 1'b1;
    run(1, 1'b0);
    drain();

    // Simultaneous fetch and store: D first, I two cycles later
    do_reset(1'b0);
    push_d(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    push_i(32'h14);
    i_addr = 32'h14; i_req = 1'b1;
    d_addr = 32'h100; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    run(2, 1'b0);
    drain();
    chk_val("t2_gap", gnt_cyc[1] - gnt_cyc[0], 2);

    // Starvation guard: D x4, I, D with both held
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) push_d(32'h200, 1'b0, 4'hF, 32'h0);
    push_i(32'h18);
    push_d(32'h200, 1'b0, 4'hF, 32'h0);
    i_addr = 32'h18; i_req = 1'b1;
    d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF; d_wdata = '0; d_req = 1'b1;
    run(6, 1'b1);
    drain();
    for (int k = 1; k < 6; k++) chk_val("t3_gap", gnt_cyc[k] - gnt_cyc[k-1], 2);

    // MEM_LAT=3 load with fetch pending
    do_reset(1'b1);
    push_d(32'h20, 1'b0, 4'hF, 32'h0);
    push_i(32'h40);
    i_addr = 32'h40; i_req = 1'b1;
    d_addr = 32'h20; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    run(2, 1'b0);
    drain();
    chk_val("t4_gap", gnt_cyc[1] - gnt_cyc[0], 4);

    // Reset one cycle into a MEM_LAT=3 load, request held throughout
    do_reset(1'b1);
    push_d(32'h20, 1'b0, 4'hF, 32'h0);
    d_addr = 32'h20; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    @(negedge clk);
    chk_val("t5_gnt", d_gnt, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    push_d(32'h20, 1'b0, 4'hF, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_val("t5_regnt", d_gnt, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
    drain();

    // Byte enables forwarded unchanged: store be=0011, load be=0001
    do_reset(1'b0);
    push_d(32'h301, 1'b1, 4'b0011, 32'h1234_5678);
    d_addr = 32'h301; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h1234_5678; d_req = 1'b1;
    run(1, 1'b0);
    push_d(32'h302, 1'b0, 4'b0001, 32'h0);
    d_addr = 32'h302; d_we = 1'b0; d_be = 4'b0001; d_wdata = '0; d_req = 1'b1;
    run(1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
